// File: rtl/out_port_ctrl_pkg.sv
// Shared constants for the router output-port controller: port count, packet
// width and the header field positions inside a packet.
package out_port_ctrl_pkg;
    localparam int NUM_IN = 4;
    localparam int PKT_W  = 64;
    localparam int VC_BIT = 63;
    localparam int DX_BIT = 62;
    localparam int DY_BIT = 61;
    localparam int HX_MSB = 55;
    localparam int HX_LSB = 52;
    localparam int HY_MSB = 51;
    localparam int HY_LSB = 48;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_e;
endpackage

// File: rtl/out_port_ctrl_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo N. Returns one-hot grant, winner index and an any flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] cand [N];

    // cand[k] is the requester examined k steps after the pointer
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = IW'((32'(ptr) + 32'(gi)) % N);
        end
    endgenerate

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[cand[k]]) begin
                any           = 1'b1;
                gnt[cand[k]]  = 1'b1;
                idx           = cand[k];
            end
        end
    end
endmodule

// File: rtl/out_port_ctrl.sv
// Output-port controller: one single-entry buffer per VC, loaded on the internal
// phase (VC = polarity) and drained to the link on the external phase.
module out_port_ctrl
    import out_port_ctrl_pkg::*;
#(
    parameter int NUM_IN = out_port_ctrl_pkg::NUM_IN,
    parameter int PKT_W  = out_port_ctrl_pkg::PKT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    polarity,
    input  logic [NUM_IN-1:0]       req_vc0,
    input  logic [NUM_IN-1:0]       req_vc1,
    input  logic [NUM_IN*PKT_W-1:0] di,
    output logic [NUM_IN-1:0]       gnt,
    output logic                    so,
    output logic [PKT_W-1:0]        dout,
    input  logic                    ro
);
    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [1:0]       ob_valid_q, ob_valid_d;
    logic [PKT_W-1:0] ob_data_q [2];
    logic [PKT_W-1:0] ob_data_d [2];
    logic [PTR_W-1:0] ptr_q [2];
    logic [PTR_W-1:0] ptr_d [2];

    logic [PKT_W-1:0]  di_arr [NUM_IN];
    logic              int_vc;
    logic              ext_vc;
    logic [NUM_IN-1:0] req_p;
    logic [NUM_IN-1:0] pick_gnt;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic              grant_en;
    logic              drain_en;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_di
            assign di_arr[gi] = di[gi*PKT_W +: PKT_W];
        end
    endgenerate

    assign int_vc = polarity;
    assign ext_vc = ~polarity;
    assign req_p  = (int_vc == VC1) ? req_vc1 : req_vc0;

    rr_pick #(
        .N  (NUM_IN),
        .IW (PTR_W)
    ) u_rr_pick (
        .req (req_p),
        .ptr (ptr_q[int_vc]),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Reset masks both sides so nothing is dequeued upstream or sent downstream
    assign grant_en = !reset && !ob_valid_q[int_vc] && pick_any;
    assign gnt      = grant_en ? pick_gnt : '0;
    assign so       = !reset && ob_valid_q[ext_vc];
    assign dout     = ob_data_q[ext_vc];
    assign drain_en = so && ro;

    always_comb begin
        ob_valid_d = ob_valid_q;
        ob_data_d  = ob_data_q;
        ptr_d      = ptr_q;
        if (drain_en) begin
            ob_valid_d[ext_vc] = 1'b0;
        end
        if (grant_en) begin
            ob_valid_d[int_vc] = 1'b1;
            ob_data_d[int_vc]  = di_arr[pick_idx];
            ptr_d[int_vc]      = (pick_idx == PTR_W'(NUM_IN - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ob_valid_q <= '0;
            for (int v = 0; v < 2; v++) begin
                ob_data_q[v] <= '0;
                ptr_q[v]     <= '0;
            end
        end else begin
            ob_valid_q <= ob_valid_d;
            for (int v = 0; v < 2; v++) begin
                ob_data_q[v] <= ob_data_d[v];
                ptr_q[v]     <= ptr_d[v];
            end
        end
    end
endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl: per-VC expected-packet queues filled at
// grant time, drained by an independent link monitor.
module tb_out_port_ctrl;
    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           polarity = 1'b1;
    logic [N-1:0]   req_vc0 = '0;
    logic [N-1:0]   req_vc1 = '0;
    logic [N*W-1:0] di = '0;
    logic [N-1:0]   gnt;
    logic           so;
    logic [W-1:0]   dout;
    logic           ro = 1'b1;

    logic [W-1:0] exp_q0 [$];
    logic [W-1:0] exp_q1 [$];
    int           mdl_ptr [2];
    int           checks = 0;
    int           errors = 0;
    bit           rst_prev = 1'b1;
    bit           use_fixed = 1'b0;
    logic [W-1:0] fixed_pkt = '0;

    out_port_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .req_vc0  (req_vc0),
        .req_vc1  (req_vc1),
        .di       (di),
        .gnt      (gnt),
        .so       (so),
        .dout     (dout),
        .ro       (ro)
    );

    always #5 clk = ~clk;

    function automatic int qsize(input logic v);
        return (v == 1'b0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // One router cycle: drive inputs after the falling edge, then predict gnt
    task automatic step(input logic rst, input logic [N-1:0] r0, input logic [N-1:0] r1,
                        input logic r_o);
        logic [N-1:0] exp_g;
        logic [N-1:0] r;
        logic         v;
        int           win;
        @(negedge clk);
        if (rst_prev) begin
            exp_q0.delete();
            exp_q1.delete();
            mdl_ptr[0] = 0;
            mdl_ptr[1] = 0;
        end
        reset    = rst;
        polarity = ~polarity;
        req_vc0  = r0;
        req_vc1  = r1;
        ro       = r_o;
        for (int i = 0; i < N; i++)
            di[i*W +: W] = use_fixed ? fixed_pkt : {$urandom(), $urandom()};
        #1;
        exp_g = '0;
        win   = -1;
        v     = polarity;
        r     = v ? r1 : r0;
        if (!rst && qsize(v) == 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mdl_ptr[v] + k) % N;
                if (win < 0 && r[idx]) win = idx;
            end
        end
        if (win >= 0) exp_g[win] = 1'b1;
        checks++;
        if (gnt !== exp_g) begin
            errors++;
            $display("FAIL gnt t=%0t pol=%0b got=%b exp=%b", $time, polarity, gnt, exp_g);
        end
        if (rst_prev && !rst) begin
            checks++;
            if (dout !== '0) begin
                errors++;
                $display("FAIL dout_after_reset got=%h exp=0", dout);
            end
        end
        if (win >= 0) begin
            if (v) exp_q1.push_back(di[win*W +: W]);
            else   exp_q0.push_back(di[win*W +: W]);
            mdl_ptr[v] = (win + 1) % N;
            $display("t=%0t pol=%0b grant req%0d pkt=%h", $time, polarity, win, di[win*W +: W]);
        end
        rst_prev = rst;
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, 1'b1);
        if (polarity == 1'b0) step(1'b1, '0, '0, 1'b1);
    endtask

    // Link monitor: compares so/dout with the queue of the external VC
    initial begin
        logic         e;
        logic         exp_so;
        logic [W-1:0] exp_d;
        forever begin
            @(negedge clk);
            #3;
            e      = ~polarity;
            exp_so = !reset && (qsize(e) != 0);
            checks++;
            if (so !== exp_so) begin
                errors++;
                $display("FAIL so t=%0t vc=%0b got=%b exp=%b", $time, e, so, exp_so);
            end
            if (so === 1'b1 && exp_so) begin
                exp_d = e ? exp_q1[0] : exp_q0[0];
                checks++;
                if (dout !== exp_d) begin
                    errors++;
                    $display("FAIL dout t=%0t vc=%0b got=%h exp=%h", $time, e, dout, exp_d);
                end
                if (ro) begin
                    if (e) void'(exp_q1.pop_front());
                    else   void'(exp_q0.pop_front());
                    $display("t=%0t vc=%0b sent pkt=%h", $time, e, dout);
                end
            end
        end
    end

    initial begin
        do_reset();
        // single VC0 request pair, then idle
        step(1'b0, 4'b0101, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000, 1'b1);
        // all four requesters on VC0: rotation 0,1,2,3,0
        for (int i = 0; i < 12; i++) step(1'b0, 4'b1111, 4'b0000, 1'b1);
        // one requester per VC, alternating every cycle
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, 4'b0010, 1'b1);
        // downstream stall on a loaded VC1 buffer, then release
        do_reset();
        use_fixed = 1'b1;
        fixed_pkt = 64'hA000_0000_FEED_BEEF;
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0010, 1'b0);
        use_fixed = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 4'b1111, 1'b1);
        // reset while both buffers hold packets
        step(1'b0, 4'b1111, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 4'b1111, 1'b1);
        if (polarity == 1'b0) step(1'b1, 4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b1111, 1'b1);
        // randomized traffic with link backpressure and occasional reset
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(63) == 0), 4'($urandom()), 4'($urandom()),
                 ($urandom_range(3) != 0));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
